// File: rtl/counter_hexdisp_pkg.sv
// Shared constants for the hex counter display: segment width and the
// hex-to-seven-segment lookup (a on bit 0, active-high).
package counter_hexdisp_pkg;

    localparam int unsigned seg_w = 7;
    localparam int unsigned nib_w = 4;

    // Entry n holds the pattern for hex digit n; index 0 is the rightmost element.
    localparam logic [15:0][seg_w-1:0] hex_seg_lut = {
        7'h71, 7'h79, 7'h5E, 7'h39,   // F E d C
        7'h7C, 7'h77, 7'h6F, 7'h7F,   // b A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
    };

endpackage : counter_hexdisp_pkg

// File: rtl/counter_hexdisp_sevenseg.sv
// Combinational hex digit to seven-segment decoder with optional segment
// order reversal and active-low output.
module sevenseg
    import counter_hexdisp_pkg::*;
#(
    parameter bit zero_is_on        = 1'b0,
    parameter bit inverse_numbering = 1'b0
) (
    input  logic [nib_w-1:0] in_digit,
    output logic [seg_w-1:0] out_leds
);

    logic [seg_w-1:0] base_pat;
    logic [seg_w-1:0] rev_pat;

    assign base_pat = hex_seg_lut[in_digit];

    for (genvar j = 0; j < seg_w; j++) begin : g_rev
        assign rev_pat[j] = base_pat[seg_w-1-j];
    end

    // Reordering first, then polarity, so inversion covers the final layout.
    always_comb begin
        out_leds = base_pat;
        if (inverse_numbering) begin
            out_leds = rev_pat;
        end
        if (zero_is_on) begin
            out_leds = ~out_leds;
        end
    end

endmodule : sevenseg

// File: rtl/counter_hexdisp.sv
// Free-running up-counter whose value is decoded onto one seven-segment
// pattern per hex digit.
module counter_hexdisp
    import counter_hexdisp_pkg::*;
#(
    parameter int unsigned num_ctrbits       = 4,
    parameter bit          zero_is_on        = 1'b0,
    parameter bit          inverse_numbering = 1'b0
) (
    input  logic                                        in_clk,
    input  logic                                        in_rst,
    output logic [num_ctrbits-1:0]                      out_ctr,
    output logic [seg_w*((num_ctrbits+3)/4)-1:0]        out_leds
);

    localparam int unsigned num_digits = (num_ctrbits + 3) / 4;
    localparam int unsigned ext_w      = nib_w * num_digits;

    logic [ext_w-1:0] ctr_ext;

    // Wraps naturally at all-ones; no enable and no overflow flag.
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            out_ctr <= '0;
        end else begin
            out_ctr <= out_ctr + num_ctrbits'(1);
        end
    end

    // Top nibble is zero-extended when the width is not a multiple of 4.
    assign ctr_ext = ext_w'(out_ctr);

    for (genvar k = 0; k < num_digits; k++) begin : g_digit
        sevenseg #(
            .zero_is_on       (zero_is_on),
            .inverse_numbering(inverse_numbering)
        ) u_seg (
            .in_digit(ctr_ext[nib_w*k +: nib_w]),
            .out_leds(out_leds[seg_w*k +: seg_w])
        );
    end

endmodule : counter_hexdisp

// File: tb/tb_counter_hexdisp.sv
// Directed bench for counter_hexdisp: four parameter variants share one
// clock and reset; expectations from a reference model go through a queue.
module tb_counter_hexdisp;

    logic        clk;
    logic        rst_n;
    logic [3:0]  ctr_def, ctr_zio, ctr_inv;
    logic [6:0]  leds_def, leds_zio, leds_inv;
    logic [5:0]  ctr_w6;
    logic [13:0] leds_w6;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0]  c4;
        logic [6:0]  ld;
        logic [6:0]  lz;
        logic [6:0]  li;
        logic [5:0]  c6;
        logic [13:0] l6;
    } exp_t;

    exp_t sb[$];
    int   m4;
    int   m6;

    counter_hexdisp #(.num_ctrbits(4)) u_def (
        .in_clk(clk), .in_rst(rst_n), .out_ctr(ctr_def), .out_leds(leds_def));
    counter_hexdisp #(.num_ctrbits(4), .zero_is_on(1'b1)) u_zio (
        .in_clk(clk), .in_rst(rst_n), .out_ctr(ctr_zio), .out_leds(leds_zio));
    counter_hexdisp #(.num_ctrbits(4), .inverse_numbering(1'b1)) u_inv (
        .in_clk(clk), .in_rst(rst_n), .out_ctr(ctr_inv), .out_leds(leds_inv));
    counter_hexdisp #(.num_ctrbits(6)) u_w6 (
        .in_clk(clk), .in_rst(rst_n), .out_ctr(ctr_w6), .out_leds(leds_w6));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input int nib, input bit zio, input bit inv);
        logic [6:0] p;
        logic [6:0] r;
        case (nib)
            0: p = 7'h3F;  1: p = 7'h06;  2: p = 7'h5B;  3: p = 7'h4F;
            4: p = 7'h66;  5: p = 7'h6D;  6: p = 7'h7D;  7: p = 7'h07;
            8: p = 7'h7F;  9: p = 7'h6F;  10: p = 7'h77; 11: p = 7'h7C;
            12: p = 7'h39; 13: p = 7'h5E; 14: p = 7'h79; default: p = 7'h71;
        endcase
        r = p;
        if (inv) for (int j = 0; j < 7; j++) r[j] = p[6-j];
        if (zio) r = ~r;
        return r;
    endfunction

    function automatic exp_t model_exp();
        exp_t e;
        e.c4 = 4'(m4);
        e.ld = ref_seg(m4, 1'b0, 1'b0);
        e.lz = ref_seg(m4, 1'b1, 1'b0);
        e.li = ref_seg(m4, 1'b0, 1'b1);
        e.c6 = 6'(m6);
        e.l6 = {ref_seg(m6 / 16, 1'b0, 1'b0), ref_seg(m6 % 16, 1'b0, 1'b0)};
        return e;
    endfunction

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_pop(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            cmp({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        cmp({tag, "_ctr"},      32'(ctr_def),  32'(e.c4));
        cmp({tag, "_leds"},     32'(leds_def), 32'(e.ld));
        cmp({tag, "_zio_leds"}, 32'(leds_zio), 32'(e.lz));
        cmp({tag, "_inv_leds"}, 32'(leds_inv), 32'(e.li));
        cmp({tag, "_w6_ctr"},   32'(ctr_w6),   32'(e.c6));
        cmp({tag, "_w6_leds"},  32'(leds_w6),  32'(e.l6));
    endtask

    // One rising edge: advance the model, queue the expectation, compare on the falling edge.
    task automatic tick(input string tag);
        @(posedge clk);
        m4 = (m4 + 1) % 16;
        m6 = (m6 + 1) % 64;
        sb.push_back(model_exp());
        @(negedge clk);
        check_pop(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        m4 = 0;
        m6 = 0;
        repeat (3) @(negedge clk);
        sb.push_back(model_exp());
        check_pop("reset");
        cmp("reset_leds_const", 32'(leds_def), 32'h3F);
        cmp("reset_zio_const",  32'(leds_zio), 32'h40);
        cmp("reset_inv_const",  32'(leds_inv), 32'h7E);
        cmp("reset_w6_const",   32'(leds_w6),  32'({7'h3F, 7'h3F}));

        rst_n = 1'b1;
        tick("edge1");
        cmp("edge1_leds_const", 32'(leds_def), 32'h06);
        cmp("edge1_inv_const",  32'(leds_inv), 32'h30);
        for (int i = 2; i <= 16; i++) begin
            tick("wrap");
            if (i == 8) begin
                cmp("edge8_leds_const", 32'(leds_def), 32'h7F);
                cmp("edge8_zio_const",  32'(leds_zio), 32'h00);
            end
            if (i == 15) begin
                cmp("edgeF_leds_const", 32'(leds_def), 32'h71);
                cmp("edgeF_inv_const",  32'(leds_inv), 32'h47);
            end
        end
        cmp("wrap0_ctr_const", 32'(ctr_def), 32'h0);
        tick("edge17");
        cmp("edge17_ctr_const", 32'(ctr_def), 32'h1);

        // Count to A, then pull reset low between edges.
        repeat (9) tick("to_a");
        cmp("at_a_ctr_const", 32'(ctr_def), 32'hA);
        @(posedge clk);
        m4 = (m4 + 1) % 16;
        m6 = (m6 + 1) % 64;
        #2;
        sb.push_back(model_exp());
        check_pop("pre_async");
        rst_n = 1'b0;
        m4 = 0;
        m6 = 0;
        #1;
        sb.push_back(model_exp());
        check_pop("async_rst");
        cmp("async_leds_const", 32'(leds_def), 32'h3F);
        @(posedge clk);
        @(negedge clk);
        sb.push_back(model_exp());
        check_pop("rst_held");
        rst_n = 1'b1;
        tick("resume");
        cmp("resume_ctr_const", 32'(ctr_def), 32'h1);

        // Wider counter: reach 0x13, then wrap after 64 edges total.
        repeat (18) tick("w6_run");
        cmp("w6_13_ctr_const",  32'(ctr_w6),  32'h13);
        cmp("w6_13_leds_const", 32'(leds_w6), 32'({7'h06, 7'h4F}));
        repeat (45) tick("w6_wrap");
        cmp("w6_wrap_ctr_const",  32'(ctr_w6),  32'h0);
        cmp("w6_wrap_leds_const", 32'(leds_w6), 32'({7'h3F, 7'h3F}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_counter_hexdisp
